// File: rtl/s2p_sched_if.sv
// rtl/s2p_sched_if.sv - response channel between the s2p scheduler and its consumer
//
// Purpose: carries the tagged response word from the scheduler (master) to the
//          consumer (slave), using a valid/ack handshake.
// Signals:
//   valid    master->slave  response word available
//   data     master->slave  captured 16-bit word (0 on abort)
//   id       master->slave  index of the requester that owns the response
//   timeout  master->slave  response is an abort
//   ack      slave->master  consumer accepts the response
interface s2p_sched_if #(
  parameter int IDW = 2
);
  logic           valid;
  logic [15:0]    data;
  logic [IDW-1:0] id;
  logic           timeout;
  logic           ack;

  modport master (output valid, output data, output id, output timeout, input ack);
  modport slave  (input valid, input data, input id, input timeout, output ack);
endinterface

// File: rtl/s2p_sched.sv
// rtl/s2p_sched.sv - round-robin scheduler sharing one serial-to-parallel deserializer
//
// Purpose: grants one of NREQ serial requesters at a time, routes its serial line
//          and word length to the deserializer, runs the deserializer until it
//          reports a complete word (or times out) and returns the word on a
//          valid/ack response channel tagged with the requester id.
// Optional feature: define S2P_SCHED_PRIO_EN to give requester 0 absolute priority.
// Ports:
//   clk          system clock, all state on posedge
//   reset        asynchronous active-low reset
//   req          per-requester request level
//   req_len      4-bit word length per requester, [4i+3:4i]
//   req_sdata    per-requester serial line
//   gnt          one-hot grant, held for the whole transaction
//   s2p_enable   deserializer enable
//   s2p_len      length forwarded to the deserializer
//   s2p_sdata    serial line of the granted requester, 0 when idle
//   s2p_ready    deserializer word-complete flag
//   s2p_data     deserializer parallel word
//   rsp          response channel (master side)
//   busy         high whenever the FSM is not in IDLE
module s2p_sched #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_len,
  input  logic [NREQ-1:0]   req_sdata,
  output logic [NREQ-1:0]   gnt,
  output logic              s2p_enable,
  output logic [3:0]        s2p_len,
  output logic              s2p_sdata,
  input  logic              s2p_ready,
  input  logic [15:0]       s2p_data,
  s2p_sched_if.master       rsp,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, SETUP, RUN, DELIVER, GAP} state_t;

  localparam logic [9:0]      TO_LAST  = 10'(TIMEOUT - 1);
  localparam logic [IDW-1:0]  PTR_INIT = IDW'(NREQ - 1);

  state_t          state, state_nx;
  logic [IDW-1:0]  ptr;
  logic [9:0]      cnt;
  logic [NREQ-1:0] cand;
  logic            any_req;
  logic [IDW-1:0]  sel;
  logic [3:0]      sel_len;
  logic            timed_out;

  assign timed_out = (cnt == TO_LAST);

  // Arbitration: first candidate after the last-granted pointer, wrapping.
  always_comb begin
    cand    = req;
    sel     = '0;
    any_req = 1'b0;
`ifdef S2P_SCHED_PRIO_EN
    // Requester 0 is handled outside the rotation.
    cand[0] = 1'b0;
`endif
    for (int off = 1; off <= NREQ; off++) begin
      if (!any_req && cand[(int'(ptr) + off) % NREQ]) begin
        sel     = IDW'((int'(ptr) + off) % NREQ);
        any_req = 1'b1;
      end
    end
`ifdef S2P_SCHED_PRIO_EN
    if (req[0]) begin
      sel     = '0;
      any_req = 1'b1;
    end
`endif
    sel_len = req_len[4*int'(sel) +: 4];
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = (sel_len == 4'd0) ? DELIVER : SETUP;
      SETUP:   state_nx = RUN;
      RUN:     if (s2p_ready || timed_out) state_nx = DELIVER;
      DELIVER: if (rsp.ack) state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    s2p_enable = (state == RUN);
    rsp.valid  = (state == DELIVER);
    busy       = (state != IDLE);
    s2p_sdata  = |(gnt & req_sdata);
  end

  // Grant, pointer, counter and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt         <= '0;
      s2p_len     <= '0;
      ptr         <= PTR_INIT;
      cnt         <= '0;
      rsp.data    <= '0;
      rsp.id      <= '0;
      rsp.timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << sel;
            s2p_len <= sel_len;
            rsp.id  <= sel;
`ifdef S2P_SCHED_PRIO_EN
            if (!req[0]) ptr <= sel;
`else
            ptr <= sel;
`endif
            // Zero-length words skip the deserializer entirely.
            if (sel_len == 4'd0) begin
              rsp.data    <= '0;
              rsp.timeout <= 1'b0;
            end
          end
        end
        SETUP: cnt <= '0;
        RUN: begin
          cnt <= cnt + 10'd1;
          // Ready takes precedence over a coincident timeout.
          if (s2p_ready) begin
            rsp.data    <= s2p_data;
            rsp.timeout <= 1'b0;
          end else if (timed_out) begin
            rsp.data    <= '0;
            rsp.timeout <= 1'b1;
          end
        end
        DELIVER: if (rsp.ack) gnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_s2p_sched.sv
// tb/tb_s2p_sched.sv - self-checking bench for s2p_sched with a deserializer model
module tb_s2p_sched;
  localparam int NREQ = 4;
  localparam int IDW = 2;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = 4'b0;
  logic [15:0] req_len;
  logic [3:0]  req_sdata;
  logic [3:0]  gnt;
  logic        s2p_enable;
  logic [3:0]  s2p_len;
  logic        s2p_sdata;
  logic        s2p_ready;
  logic [15:0] s2p_data;
  logic        busy;

  logic [3:0]  lens [4];
  logic [15:0] pat [4];
  int          total = 0;
  int          bad = 0;
  int          ref_ptr = NREQ - 1;
  bit          no_ready = 1'b0;

  logic [15:0] d_word = '0;
  logic [4:0]  d_cnt = '0;
  logic        d_rdy = 1'b0;

  s2p_sched_if #(.IDW(IDW)) rsp_if ();

  s2p_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_len(req_len), .req_sdata(req_sdata),
    .gnt(gnt), .s2p_enable(s2p_enable), .s2p_len(s2p_len), .s2p_sdata(s2p_sdata),
    .s2p_ready(s2p_ready), .s2p_data(s2p_data), .rsp(rsp_if.master), .busy(busy)
  );

  always #5 clk = ~clk;

  // Each requester presents its pattern MSB-first, paced by the deserializer bit count.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_len[4*i +: 4] = lens[i];
      req_sdata[i] = 1'b0;
      if (int'(d_cnt) < int'(lens[i])) req_sdata[i] = pat[i][int'(lens[i]) - 1 - int'(d_cnt)];
    end
  end

  // Deserializer model: clears while disabled, shifts one bit per enabled cycle,
  // raises ready (registered) once s2p_len bits have been collected.
  always @(posedge clk) begin
    if (!s2p_enable) begin
      d_word <= '0; d_cnt <= '0; d_rdy <= 1'b0;
    end else if (!d_rdy) begin
      d_word <= {d_word[14:0], s2p_sdata};
      d_cnt  <= d_cnt + 5'd1;
      if (!no_ready && (int'(d_cnt) + 1 == int'(s2p_len))) d_rdy <= 1'b1;
    end
  end
  assign s2p_ready = d_rdy;
  assign s2p_data  = d_word;

  // Reference arbiter: next grant from the rules, updating the reference pointer.
  function automatic int ref_grant(input logic [3:0] r);
    int c;
`ifdef S2P_SCHED_PRIO_EN
    if (r[0]) return 0;
    for (int off = 1; off <= NREQ; off++) begin
      c = (ref_ptr + off) % NREQ;
      if (c != 0 && r[c]) begin ref_ptr = c; return c; end
    end
`else
    for (int off = 1; off <= NREQ; off++) begin
      c = (ref_ptr + off) % NREQ;
      if (r[c]) begin ref_ptr = c; return c; end
    end
`endif
    return -1;
  endfunction

  function automatic logic [15:0] ref_word(input int s);
    logic [15:0] m;
    if (lens[s] == 4'd0) return 16'h0;
    m = (16'h1 << lens[s]) - 16'h1;
    return pat[s] & m;
  endfunction

  task automatic do_reset();
    reset = 1'b0; req = 4'b0; rsp_if.ack = 1'b0; no_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1; ref_ptr = NREQ - 1;
    @(negedge clk);
  endtask

  task automatic wait_gnt(output logic [3:0] g, output int n);
    n = 0;
    while (gnt === 4'b0 && n < 300) begin @(negedge clk); n++; end
    g = gnt;
  endtask

  task automatic wait_valid(output int n, output bit en_seen);
    n = 0; en_seen = 1'b0;
    while (rsp_if.valid !== 1'b1 && n < 300) begin
      if (s2p_enable === 1'b1) en_seen = 1'b1;
      @(negedge clk); n++;
    end
  endtask

  task automatic do_ack();
    rsp_if.ack = 1'b1;
    @(negedge clk);
    rsp_if.ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 4'b0; rsp_if.ack = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({gnt, s2p_enable, s2p_len, rsp_if.valid, busy} !== 11'b0) begin bad++;
      $display("FAIL reset_ctrl: got %b exp 0", {gnt, s2p_enable, s2p_len, rsp_if.valid, busy}); end
    total++; if ({rsp_if.data, rsp_if.id, rsp_if.timeout} !== 19'b0) begin bad++;
      $display("FAIL reset_rsp: got %h exp 0", {rsp_if.data, rsp_if.id, rsp_if.timeout}); end
    total++; if (s2p_sdata !== 1'b0) begin bad++;
      $display("FAIL reset_sdata: got %b exp 0", s2p_sdata); end
    do_reset();
  endtask

  task automatic test_single();
    logic [3:0] g; int n; bit en;
    do_reset();
    lens[0] = 4'd8; pat[0] = 16'h005A; req = 4'b0001;
    wait_gnt(g, n);
    void'(ref_grant(req));
    total++; if (g !== 4'b0001) begin bad++; $display("FAIL single_gnt: got %b exp 0001", g); end
    total++; if (s2p_enable !== 1'b0) begin bad++; $display("FAIL single_setup_en: got %b exp 0", s2p_enable); end
    @(negedge clk);
    total++; if (s2p_enable !== 1'b1) begin bad++; $display("FAIL single_run_en: got %b exp 1", s2p_enable); end
    wait_valid(n, en);
    total++; if (n + 1 !== 10) begin bad++; $display("FAIL single_latency: got %0d exp 10", n + 1); end
    total++; if (rsp_if.data !== 16'h005A) begin bad++; $display("FAIL single_data: got %h exp 005a", rsp_if.data); end
    total++; if (rsp_if.id !== 2'd0 || rsp_if.timeout !== 1'b0) begin bad++;
      $display("FAIL single_id_to: got %0d/%b exp 0/0", rsp_if.id, rsp_if.timeout); end
    do_ack(); req = 4'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] g; int n, exp, idle, t; bit en;
    do_reset();
    for (int i = 0; i < 4; i++) begin lens[i] = 4'd2; pat[i] = 16'($urandom); end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(g, n);
      exp = ref_grant(req);
      total++; if (g !== 4'(1 << exp)) begin bad++; $display("FAIL rr_gnt%0d: got %b exp %b", k, g, 4'(1 << exp)); end
      wait_valid(n, en);
      total++; if (rsp_if.id !== 2'(exp) || rsp_if.data !== ref_word(exp)) begin bad++;
        $display("FAIL rr_rsp%0d: got %0d/%h exp %0d/%h", k, rsp_if.id, rsp_if.data, exp, ref_word(exp)); end
      do_ack();
      if (k < 4) begin
        idle = 0; t = 0;
        do begin @(negedge clk); if (busy === 1'b0) idle++; t++; end while (gnt === 4'b0 && t < 50);
        total++; if (idle !== 1) begin bad++; $display("FAIL rr_gap%0d: got %0d exp 1", k, idle); end
      end
    end
    req = 4'b0;
  endtask

  task automatic test_timeout();
    logic [3:0] g; int n; bit en;
    do_reset();
    no_ready = 1'b1; lens[0] = 4'd8; req = 4'b0001;
    wait_gnt(g, n);
    void'(ref_grant(req));
    req = 4'b0;
    wait_valid(n, en);
    total++; if (n !== TIMEOUT + 1) begin bad++; $display("FAIL to_latency: got %0d exp %0d", n, TIMEOUT + 1); end
    total++; if (rsp_if.timeout !== 1'b1 || rsp_if.data !== 16'h0) begin bad++;
      $display("FAIL to_rsp: got %b/%h exp 1/0000", rsp_if.timeout, rsp_if.data); end
    total++; if (s2p_enable !== 1'b0) begin bad++; $display("FAIL to_deliver_en: got %b exp 0", s2p_enable); end
    do_ack(); no_ready = 1'b0;
  endtask

  task automatic test_zero_len();
    logic [3:0] g; int n; bit en;
    do_reset();
    lens[0] = 4'd8; pat[0] = 16'h005A; req = 4'b0001;
    wait_gnt(g, n); void'(ref_grant(req));
    wait_valid(n, en); do_ack();
    lens[2] = 4'd0; req = 4'b0100;
    wait_gnt(g, n); void'(ref_grant(req));
    total++; if (g !== 4'b0100) begin bad++; $display("FAIL zl_gnt: got %b exp 0100", g); end
    wait_valid(n, en);
    total++; if (n !== 0 || en !== 1'b0 || s2p_enable !== 1'b0) begin bad++;
      $display("FAIL zl_no_enable: got lat=%0d en=%b exp lat=0 en=0", n, en | s2p_enable); end
    total++; if (rsp_if.data !== 16'h0 || rsp_if.id !== 2'd2 || rsp_if.timeout !== 1'b0) begin bad++;
      $display("FAIL zl_rsp: got %h/%0d/%b exp 0000/2/0", rsp_if.data, rsp_if.id, rsp_if.timeout); end
    do_ack(); req = 4'b0;
  endtask

  task automatic test_ack_hold();
    logic [3:0] g; int n, exp, errs; bit en; logic [15:0] d;
    do_reset();
    lens[1] = 4'd5; pat[1] = 16'($urandom); req = 4'b0010;
    wait_gnt(g, n); exp = ref_grant(req);
    wait_valid(n, en);
    d = ref_word(exp);
    total++; if (rsp_if.data !== d) begin bad++; $display("FAIL hold_data: got %h exp %h", rsp_if.data, d); end
    req = 4'b0011; errs = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_if.valid !== 1'b1 || rsp_if.data !== d || rsp_if.id !== 2'd1 || gnt !== 4'b0010) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL hold_stable: got %0d unstable cycles exp 0", errs); end
    do_ack();
    total++; if (gnt !== 4'b0 || rsp_if.valid !== 1'b0) begin bad++;
      $display("FAIL hold_gap: got gnt=%b valid=%b exp 0/0", gnt, rsp_if.valid); end
    wait_gnt(g, n); exp = ref_grant(req);
    total++; if (g !== 4'(1 << exp)) begin bad++; $display("FAIL hold_next_gnt: got %b exp %b", g, 4'(1 << exp)); end
    wait_valid(n, en); do_ack(); req = 4'b0;
  endtask

  task automatic test_reset_midrun();
    logic [3:0] g; int n, seen;
    do_reset();
    lens[0] = 4'd15; req = 4'b0001;
    wait_gnt(g, n);
    repeat (3) @(negedge clk);
    total++; if (s2p_enable !== 1'b1) begin bad++; $display("FAIL mr_running: got %b exp 1", s2p_enable); end
    #2 reset = 1'b0;
    #1;
    total++; if ({gnt, s2p_enable, s2p_len, rsp_if.valid, busy} !== 11'b0 || {rsp_if.data, rsp_if.id, rsp_if.timeout} !== 19'b0) begin bad++;
      $display("FAIL mr_async: got %b %h exp all 0", {gnt, s2p_enable, s2p_len, rsp_if.valid, busy}, {rsp_if.data, rsp_if.id, rsp_if.timeout}); end
    req = 4'b0;
    @(negedge clk); reset = 1'b1; ref_ptr = NREQ - 1; seen = 0;
    repeat (10) begin @(negedge clk); if (rsp_if.valid === 1'b1 || gnt !== 4'b0) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL mr_no_rsp: got %0d active cycles exp 0", seen); end
  endtask

  task automatic test_random();
    logic [3:0] g; int n, exp, errs; bit en;
    do_reset();
    errs = 0;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 4; i++) begin lens[i] = 4'($urandom_range(0, 15)); pat[i] = 16'($urandom); end
      req = 4'($urandom_range(1, 15));
      exp = ref_grant(req);
      wait_gnt(g, n);
      if (g !== 4'(1 << exp)) begin errs++; $display("FAIL rnd_gnt%0d: got %b exp %b", t, g, 4'(1 << exp)); end
      wait_valid(n, en);
      if (n !== ((lens[exp] == 4'd0) ? 0 : int'(lens[exp]) + 2)) begin errs++;
        $display("FAIL rnd_lat%0d: got %0d exp len %0d + 2", t, n, lens[exp]); end
      if (rsp_if.data !== ref_word(exp) || rsp_if.id !== 2'(exp) || rsp_if.timeout !== 1'b0) begin errs++;
        $display("FAIL rnd_rsp%0d: got %h/%0d/%b exp %h/%0d/0", t, rsp_if.data, rsp_if.id, rsp_if.timeout, ref_word(exp), exp); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_ack();
    end
    req = 4'b0;
    total++; if (errs !== 0) begin bad++; $display("FAIL rnd_summary: got %0d errors exp 0", errs); end
  endtask

`ifdef S2P_SCHED_PRIO_EN
  task automatic test_prio();
    logic [3:0] g; int n; bit en;
    logic [3:0] order [5];
    do_reset();
    for (int i = 0; i < 4; i++) begin lens[i] = 4'd3; pat[i] = 16'($urandom); end
    order[0] = 4'b0001; order[1] = 4'b0001; order[2] = 4'b0001; order[3] = 4'b0010; order[4] = 4'b1000;
    req = 4'b1011;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(g, n);
      total++; if (g !== order[k]) begin bad++; $display("FAIL prio_gnt%0d: got %b exp %b", k, g, order[k]); end
      wait_valid(n, en);
      do_ack();
      if (k == 2) req = 4'b1010;
    end
    req = 4'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) begin lens[i] = 4'd1; pat[i] = 16'h0; end
    rsp_if.ack = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_zero_len();
    test_ack_hold();
    test_reset_midrun();
    test_random();
`ifdef S2P_SCHED_PRIO_EN
    test_prio();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
